deskew_collect: RTL and testbench
=================================

DESKEW_COLLECT -- requirements
Module: deskew_collect

Interface
REQ-001 Parameter D_W, default 8, SHALL set the per-column data width in bits.
REQ-002 Parameter COLS, default 4, SHALL set the number of systolic-array output columns (>=2).
REQ-003 Parameter DEPTH, default 4, SHALL set the output FIFO depth in rows, power of two, >=2.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  SHALL be an asynchronous, active-high reset.
REQ-006 in_v  input  COLS  SHALL be the per-column valid; bit j qualifies column j.
REQ-007 in_d  input  COLS*D_W  SHALL be the column data; column j occupies bits [j*D_W +: D_W].
REQ-008 out_valid  output  1  SHALL indicate that out_data holds an aligned row.
REQ-009 out_ready  input  1  SHALL be the downstream accept.
REQ-010 out_data  output  COLS*D_W  SHALL carry the aligned row, with the same column packing as in_d.
REQ-011 overflow  output  1  SHALL be a sticky flag for an aligned row dropped because the FIFO was full.
REQ-012 misalign  output  1  SHALL be a sticky flag for an aligned-stage valid mismatch.
REQ-013 row_cnt  output  16  SHALL count the rows written into the FIFO.

Function
REQ-014 Input skew contract: a row's column j SHALL arrive exactly j cycles after its column 0; the input side has no backpressure.
REQ-015 Column j SHALL pass through COLS-1-j delay registers plus one align register; data and valid SHALL be delayed identically.
REQ-016 A row whose column 0 is sampled at edge t0 SHALL be present in the align stage during cycle t0+COLS.
REQ-017 Aligned-valid SHALL be the AND of all COLS delayed valids.
REQ-018 If the delayed valids in the align stage are neither all 0 nor all 1, misalign SHALL set; the partial row SHALL be discarded and not written.
REQ-019 Write: aligned-valid with the FIFO not full SHALL write the row and increment row_cnt, which wraps 0xFFFF->0.
REQ-020 Aligned-valid with the FIFO full and no pop in the same cycle SHALL drop the row, set overflow, and leave row_cnt unchanged.
REQ-021 Pop: out_valid && out_ready SHALL remove the head row on that edge.
REQ-022 Full with simultaneous pop and write SHALL perform both; there is no overflow and occupancy stays DEPTH.
REQ-023 Empty with a write SHALL give out_valid=1 from the next cycle; there is no same-cycle bypass.
REQ-024 End-to-end latency with the FIFO empty SHALL be COLS+1 cycles from column 0 sample to out_valid.
REQ-025 out_valid SHALL equal (occupancy != 0), and out_data SHALL equal the head entry.
REQ-026 While out_valid=1 and out_ready=0, out_data SHALL hold stable.
REQ-027 Read/write pointers SHALL use log2(DEPTH)+1 bits, with the MSB distinguishing full from empty; pointers SHALL wrap modulo 2*DEPTH.
REQ-028 Back-to-back rows, one per cycle, SHALL be sustained with no bubbles while out_ready=1.
REQ-029 overflow and misalign SHALL clear only on reset.

Reset
REQ-030 Asserting rst SHALL, without waiting for clk, clear all delay/align registers, both pointers, row_cnt, overflow, misalign and out_valid.
REQ-031 out_data SHALL reset to 0.
REQ-032 Rows in flight or buffered when rst asserts SHALL be discarded.
REQ-033 After rst deasserts, the first sampled edge SHALL accept input normally.

Verification (COLS=4, D_W=8, DEPTH=4)
REQ-034 Single row: stimulus is in_v[j]=1 with in_d col j=0x10+j at cycle j, j=0..3, and out_ready=1. Required response: out_valid rises at cycle 5 for one cycle, out_data=0x13121110, row_cnt=1.
REQ-035 Stream: 8 consecutive skewed rows with out_ready=1. Required response: 8 consecutive out_valid cycles in order, row_cnt=8, overflow=0.
REQ-036 Overflow: out_ready=0 and 5 rows. Required response: 4 rows buffered, overflow=1, row_cnt=4; then out_ready=1 drains exactly rows 1-4 in order.
REQ-037 Full pop+write: FIFO full, out_ready=1 in the cycle a 5th row aligns. Required response: overflow stays 0, occupancy stays 4, row_cnt=5.
REQ-038 Misalign: column 2 valid suppressed for one row. Required response: misalign=1, no write, row_cnt unchanged.
REQ-039 Async reset: rst pulses mid-cycle with 2 rows buffered. Required response: out_valid=0 immediately, row_cnt=0, and a subsequent row emerges with COLS+1 latency.

Source files
------------

// File: rtl/deskew_collect.sv
// deskew_collect
//   Re-aligns the skewed output columns of a systolic array into whole rows
//   and buffers those rows in a small FIFO for a ready/valid consumer.
//   Column j of a row arrives j cycles after column 0. Column j is delayed by
//   COLS-1-j registers plus one align register, so every column of a row lands
//   in the align stage together.
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_v       per-column valid, bit j qualifies column j
//   in_d       column data, column j at [j*D_W +: D_W]
//   out_valid  FIFO not empty (head row available)
//   out_ready  downstream accept
//   out_data   head row, same column packing as in_d
//   overflow   sticky: an aligned row was dropped on a full FIFO
//   misalign   sticky: align-stage valids were a partial row
//   row_cnt    rows written into the FIFO, wraps at 16 bits
module deskew_collect #(
  parameter int D_W   = 8,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLS-1:0]     in_v,
  input  logic [COLS*D_W-1:0] in_d,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [COLS*D_W-1:0] out_data,
  output logic                overflow,
  output logic                misalign,
  output logic [15:0]         row_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [COLS-1:0]     al_v;
  logic [COLS*D_W-1:0] al_d;

  // Per-column delay line; the last stage of each chain is the align register.
  for (genvar j = 0; j < COLS; j++) begin : g_col
    localparam int N = COLS - j;
    logic [N-1:0]          v_q;
    logic [N-1:0][D_W-1:0] d_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= '0;
        d_q <= '0;
      end else begin
        v_q[0] <= in_v[j];
        d_q[0] <= in_d[j*D_W +: D_W];
        for (int k = 1; k < N; k++) begin
          v_q[k] <= v_q[k-1];
          d_q[k] <= d_q[k-1];
        end
      end
    end

    assign al_v[j]             = v_q[N-1];
    assign al_d[j*D_W +: D_W]  = d_q[N-1];
  end

  // FIFO storage; pointers carry one extra MSB to tell full from empty.
  logic [COLS*D_W-1:0] mem_q [DEPTH];
  logic [AW:0]         wr_ptr_q, wr_ptr_d;
  logic [AW:0]         rd_ptr_q, rd_ptr_d;
  logic [15:0]         row_cnt_q, row_cnt_d;
  logic                overflow_q, overflow_d;
  logic                misalign_q, misalign_d;

  logic al_all, al_part, empty, full, pop, wr_en;

  always_comb begin
    al_all  = &al_v;
    al_part = (|al_v) && !al_all;
    empty   = (wr_ptr_q == rd_ptr_q);
    full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
              (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop     = !empty && out_ready;
    // A pop on the same edge frees the slot the write needs.
    wr_en   = al_all && (!full || pop);

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    row_cnt_d  = row_cnt_q;
    overflow_d = overflow_q;
    misalign_d = misalign_q;

    if (wr_en) begin
      wr_ptr_d  = wr_ptr_q + (AW+1)'(1);
      row_cnt_d = row_cnt_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
    if (al_all && !wr_en) begin
      overflow_d = 1'b1;
    end
    if (al_part) begin
      misalign_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      row_cnt_q  <= '0;
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q[AW-1:0]] <= al_d;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      row_cnt_q  <= row_cnt_d;
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow  = overflow_q;
  assign misalign  = misalign_q;
  assign row_cnt   = row_cnt_q;

endmodule

// File: tb/tb_deskew_collect.sv
// tb_deskew_collect
//   Table-driven single-row check, directed multi-cycle sequences and a
//   randomized run, all compared against a row-level reference model that
//   rebuilds aligned rows from the input history and keeps the FIFO as a queue.
module tb_deskew_collect;

  localparam int COLS  = 4;
  localparam int D_W   = 8;
  localparam int DEPTH = 4;
  localparam int W     = COLS * D_W;
  localparam int MAXC  = 512;

  logic            clk = 1'b0;
  logic            rst;
  logic [COLS-1:0] in_v;
  logic [W-1:0]    in_d;
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_data;
  logic            overflow;
  logic            misalign;
  logic [15:0]     row_cnt;

  always #5 clk = ~clk;

  deskew_collect #(.D_W(D_W), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_v      (in_v),
    .in_d      (in_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .overflow  (overflow),
    .misalign  (misalign),
    .row_cnt   (row_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: input history of the last COLS cycles, FIFO as a queue.
  logic [W-1:0]    mq [$];
  logic [COLS-1:0] hv [$];
  logic [W-1:0]    hd [$];
  logic [15:0]     m_cnt;
  logic            m_ovf, m_mis;

  // DUT outputs sampled mid-cycle by the last call of cycle().
  logic            s_valid;
  logic [W-1:0]    s_data;
  logic [15:0]     s_cnt;
  logic            s_ovf, s_mis;

  task automatic model_reset();
    mq.delete();
    hv.delete();
    hd.delete();
    for (int i = 0; i < COLS; i++) begin
      hv.push_back('0);
      hd.push_back('0);
    end
    m_cnt = '0;
    m_ovf = 1'b0;
    m_mis = 1'b0;
  endtask

  // Called just after a rising edge; applies one cycle of inputs, checks the
  // DUT against the model mid-cycle and advances the model across the edge.
  task automatic cycle(input logic [COLS-1:0] v, input logic [W-1:0] d, input logic rdy);
    logic [COLS-1:0] av;
    logic [W-1:0]    ad;
    logic [COLS-1:0] tv;
    logic [W-1:0]    td;
    logic            pop, wr;
    in_v = v;
    in_d = d;
    out_ready = rdy;
    @(negedge clk);
    s_valid = out_valid;
    s_data  = out_data;
    s_cnt   = row_cnt;
    s_ovf   = overflow;
    s_mis   = misalign;
    chk("out_valid", out_valid, mq.size() != 0);
    if (mq.size() != 0) chk("out_data", out_data, mq[0]);
    chk("row_cnt", row_cnt, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("misalign", misalign, m_mis);
    // Row aligned this cycle: column j was driven COLS-j cycles ago.
    for (int j = 0; j < COLS; j++) begin
      tv = hv[j];
      td = hd[j];
      av[j] = tv[j];
      ad[j*D_W +: D_W] = td[j*D_W +: D_W];
    end
    pop = (mq.size() != 0) && rdy;
    wr  = 1'b0;
    if (&av) begin
      if (mq.size() < DEPTH || pop) wr = 1'b1;
      else m_ovf = 1'b1;
    end else if (|av) begin
      m_mis = 1'b1;
    end
    hv.push_back(v);
    hd.push_back(d);
    void'(hv.pop_front());
    void'(hd.pop_front());
    @(posedge clk);
    #1;
    if (pop) void'(mq.pop_front());
    if (wr) begin
      mq.push_back(ad);
      m_cnt = m_cnt + 16'd1;
    end
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic do_reset();
    in_v = '0;
    in_d = '0;
    out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_row_cnt", row_cnt, 16'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_out_data", out_data, '0);
    rst = 1'b0;
    model_reset();
  endtask

  // Stimulus schedule built from whole skewed rows.
  logic [COLS-1:0] sch_v [MAXC];
  logic [W-1:0]    sch_d [MAXC];
  logic            sch_r [MAXC];
  int nv, first_v, last_v;

  task automatic clear_sched(input logic rdy, input logic rnd);
    for (int t = 0; t < MAXC; t++) begin
      sch_v[t] = '0;
      sch_d[t] = rnd ? W'($urandom()) : '0;
      sch_r[t] = rdy;
    end
  endtask

  task automatic add_row(input int start, input logic [W-1:0] data, input int sup);
    for (int j = 0; j < COLS; j++) begin
      if (j != sup) sch_v[start+j][j] = 1'b1;
      sch_d[start+j][j*D_W +: D_W] = data[j*D_W +: D_W];
    end
  endtask

  task automatic run_sched(input int n);
    nv = 0;
    first_v = -1;
    last_v = -1;
    for (int t = 0; t < n; t++) begin
      cycle(sch_v[t], sch_d[t], sch_r[t]);
      if (s_valid) begin
        nv++;
        if (first_v < 0) first_v = t;
        last_v = t;
      end
    end
  endtask

  typedef struct {
    logic [COLS-1:0] v;
    logic [W-1:0]    d;
    logic            r;
    logic            ev;
    logic [W-1:0]    ed;
    logic [15:0]     ec;
  } vec_t;

  vec_t tbl [7];

  task automatic run_table();
    for (int i = 0; i < 7; i++) begin
      cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      chk("tbl_valid", s_valid, tbl[i].ev);
      chk("tbl_cnt", s_cnt, tbl[i].ec);
      if (tbl[i].ev) chk("tbl_data", s_data, tbl[i].ed);
    end
  endtask

  initial begin
    logic [W-1:0] dd;
    logic [W-1:0] exp_row;

    exp_row = 32'h13121110;
    for (int i = 0; i < 7; i++) begin
      dd = '0;
      if (i < COLS) dd[i*D_W +: D_W] = D_W'(8'h10 + i);
      tbl[i].v  = (i < COLS) ? COLS'(1 << i) : '0;
      tbl[i].d  = dd;
      tbl[i].r  = 1'b1;
      tbl[i].ev = (i == COLS + 1);
      tbl[i].ed = exp_row;
      tbl[i].ec = (i >= COLS + 1) ? 16'd1 : 16'd0;
    end

    rst = 1'b1;
    in_v = '0;
    in_d = '0;
    out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // Single row, latency COLS+1.
    run_table();

    // Randomized rows, occasional suppressed column, random backpressure.
    clear_sched(1'b1, 1'b1);
    for (int t = 0; t < 250; t++) begin
      sch_r[t] = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1)
        add_row(t, W'($urandom()), ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, COLS-1)) : -1);
    end
    run_sched(275);

    // Stream of 8 back-to-back rows.
    do_reset();
    clear_sched(1'b1, 1'b0);
    for (int k = 0; k < 8; k++) add_row(k, W'($urandom()), -1);
    run_sched(8 + COLS + 4);
    chk("stream_nvalid", nv, 8);
    chk("stream_contig", last_v - first_v + 1, 8);
    chk("stream_cnt", s_cnt, 16'd8);
    chk("stream_ovf", s_ovf, 1'b0);

    // Overflow: five rows into a stalled four-deep FIFO, then drain.
    do_reset();
    clear_sched(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add_row(k, W'(32'hA0A0A0A0 + k), -1);
    run_sched(13);
    chk("ovf_flag", s_ovf, 1'b1);
    chk("ovf_cnt", s_cnt, 16'd4);
    chk("ovf_valid", s_valid, 1'b1);
    clear_sched(1'b1, 1'b0);
    run_sched(8);
    chk("ovf_drain_n", nv, 4);

    // Full FIFO, pop in the cycle the fifth row aligns.
    do_reset();
    clear_sched(1'b0, 1'b0);
    for (int k = 0; k < 5; k++) add_row(k, W'(32'h50505050 + k), -1);
    sch_r[4 + COLS] = 1'b1;
    run_sched(12);
    chk("fpw_ovf", s_ovf, 1'b0);
    chk("fpw_cnt", s_cnt, 16'd5);
    clear_sched(1'b1, 1'b0);
    run_sched(8);
    chk("fpw_drain_n", nv, 4);

    // Misalign: column 2 suppressed for one row.
    do_reset();
    clear_sched(1'b1, 1'b0);
    add_row(0, W'(32'h77665544), 2);
    run_sched(COLS + 4);
    chk("mis_flag", s_mis, 1'b1);
    chk("mis_cnt", s_cnt, 16'd0);
    chk("mis_nvalid", nv, 0);

    // Async reset with two rows buffered, then a fresh row at COLS+1 latency.
    clear_sched(1'b0, 1'b0);
    add_row(0, W'(32'h11223344), -1);
    add_row(1, W'(32'h55667788), -1);
    run_sched(COLS + 3);
    chk("pre_rst_valid", s_valid, 1'b1);
    do_reset();
    run_table();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
